rf_write_buffer: RTL and testbench
==================================

Name: rf_write_buffer

Overview:
- Write-side front end for the 32x32 register file (rf_32).
- Queues register write-back requests from the pipeline in a small FIFO and drains them into the rf_32 write port, one per granted cycle.
- Provides same-cycle forwarding of the youngest pending value for the two read addresses (s, t), so reads never see stale data while writes are in flight.
- Writes to register 0 ($zero) are discarded.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  write request valid
- in_ready  output  1  buffer can accept a request; equals !full
- in_addr  input  AW  destination register
- in_data  input  DW  write data
- rf_grant  input  1  rf_32 write port available this cycle
- rf_write_enabled  output  1  to rf_32 write_enabled
- rf_write_addr  output  AW  to rf_32 write_addr
- rf_write_data  output  DW  to rf_32 write_data
- lookup_addr_s  input  AW  read address s (mirrors read_addr_s)
- lookup_addr_t  input  AW  read address t (mirrors read_addr_t)
- hit_s  output  1  pending write exists for lookup_addr_s
- hit_t  output  1  pending write exists for lookup_addr_t
- fwd_data_s  output  DW  youngest pending data for s; 0 when no hit
- fwd_data_t  output  DW  youngest pending data for t; 0 when no hit
- count  output  clog2(DEPTH)+1  occupied entries
- empty  output  1  count==0
- full  output  1  count==DEPTH

Behaviour:
- Reset:
  - Sampled at the rising clock edge when reset_n==0.
  - Clears rd_ptr, wr_ptr and count, and all entry valid bits.
  - Outputs after reset: count=0, empty=1, full=0, in_ready=1, rf_write_enabled=0, hit_s=hit_t=0, fwd_data_s=fwd_data_t=0.
  - Reset mid-operation discards all pending entries; nothing is written to rf_32.
- Push:
  - Occurs when in_valid && in_ready && in_addr!=0.
  - The entry is stored at wr_ptr, which then increments modulo DEPTH.
  - A request with in_addr==0 is accepted (handshake completes) but not stored.
- Drain (rf_write_* are combinational from the head entry):
  - rf_write_enabled = !empty && rf_grant.
  - rf_write_addr and rf_write_data = head entry; both are 0 when empty.
  - Pop occurs when rf_write_enabled==1; rd_ptr increments modulo DEPTH at the same edge that rf_32 captures the write.
- Latency: a request accepted at edge N is at the head after edge N (if the FIFO was empty) and is written to rf_32 at edge N+1 if rf_grant==1.
- Simultaneous push and pop:
  - count is unchanged.
  - in_ready stays !full, evaluated before the pop; no bypass into a full FIFO.
- Full: in_ready=0 and the request is held; the producer must keep in_valid, in_addr and in_data stable until accepted.
- Empty: no write is issued, even if rf_grant==1.
- Pointer wrap: ptr DEPTH-1 -> 0; count distinguishes full from empty.
- Forwarding (combinational):
  - Scans valid entries for a match on lookup_addr.
  - Returns the youngest match (closest to wr_ptr).
  - lookup_addr==0 never hits.
  - The head entry being popped this cycle still hits in this cycle.
  - The request being pushed this cycle does not hit until the next cycle.
- Arithmetic: count updates +1 on push only, -1 on pop only, 0 on both or neither; never exceeds DEPTH or goes below 0.

Test Plan:
- Reset then idle -> count=0, empty=1, in_ready=1, rf_write_enabled=0, hit_s=0 for all 32 lookup_addr_s values.
- rf_grant=0; push (3, 0x22222222), (5, 0x44444444), (3, 0xDEADBEEF), (7, 0x66666666) -> full=1, in_ready=0. lookup_addr_s=3 -> hit_s=1, fwd_data_s=0xDEADBEEF. lookup_addr_t=9 -> hit_t=0.
- Continuing from the previous case, raise rf_grant=1 for 4 cycles -> rf_32 receives writes in order 3:22222222, 5:44444444, 3:DEADBEEF, 7:66666666. Then empty=1, and dut register_file[3]==0xDEADBEEF.
- Push (0, 0x12345678) with rf_grant=1 -> in_ready=1, count stays 0, no rf write issued, register_file[0] unchanged.
- Hold in_valid=1 and rf_grant=1 with a new address each cycle (1..8) -> count constant at 1 after the first cycle, one write per cycle, pointers wrap past DEPTH with no loss.
- Fill 3 entries, assert reset_n=0 for one edge -> count=0, rf_write_enabled=0, no rf_32 writes occur afterward, hit_s=0.

Source files
------------

// File: rtl/rf_write_buffer_if.sv
// rtl/rf_write_buffer_if.sv - request, drain, forwarding and status signals of rf_write_buffer
interface rf_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          rf_grant;
    logic          rf_write_enabled;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] lookup_addr_s;
    logic [AW-1:0] lookup_addr_t;
    logic          hit_s;
    logic          hit_t;
    logic [DW-1:0] fwd_data_s;
    logic [DW-1:0] fwd_data_t;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    modport master (
        output in_valid, in_addr, in_data, rf_grant, lookup_addr_s, lookup_addr_t,
        input  in_ready, rf_write_enabled, rf_write_addr, rf_write_data,
        input  hit_s, hit_t, fwd_data_s, fwd_data_t, count, empty, full
    );

    modport slave (
        input  in_valid, in_addr, in_data, rf_grant, lookup_addr_s, lookup_addr_t,
        output in_ready, rf_write_enabled, rf_write_addr, rf_write_data,
        output hit_s, hit_t, fwd_data_s, fwd_data_t, count, empty, full
    );
endinterface

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - write-back FIFO in front of rf_32 with youngest-entry read forwarding
module rf_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    rf_write_buffer_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign push  = bus.in_valid && !full && (bus.in_addr != '0);
    assign pop   = !empty && bus.rf_grant;

    assign bus.in_ready         = !full;
    assign bus.empty            = empty;
    assign bus.full             = full;
    assign bus.count            = count_q;
    assign bus.rf_write_enabled = pop;
    assign bus.rf_write_addr    = empty ? '0 : addr_q[rd_ptr_q];
    assign bus.rf_write_data    = empty ? '0 : data_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        // The head slot is cleared before the new entry is written, so a push into
        // the slot vacated this cycle is never lost.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = bus.in_addr;
            data_d[wr_ptr_q]  = bus.in_data;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    logic [PW-1:0] idx;
    always_comb begin
        idx            = '0;
        bus.hit_s      = 1'b0;
        bus.hit_t      = 1'b0;
        bus.fwd_data_s = '0;
        bus.fwd_data_t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (valid_q[idx] && (bus.lookup_addr_s != '0) && (addr_q[idx] == bus.lookup_addr_s)) begin
                bus.hit_s      = 1'b1;
                bus.fwd_data_s = data_q[idx];
            end
            if (valid_q[idx] && (bus.lookup_addr_t != '0) && (addr_q[idx] == bus.lookup_addr_t)) begin
                bus.hit_t      = 1'b1;
                bus.fwd_data_t = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_rf_write_buffer.sv
// tb/tb_rf_write_buffer.sv - directed self-checking bench for rf_write_buffer with an rf_32 model
module tb_rf_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   wr_cnt;
    logic [DW-1:0] rf_mem [32];

    rf_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    rf_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model fed from the drain port.
    initial begin
        wr_cnt = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    end
    always @(posedge clock) begin
        if (bus.rf_write_enabled) begin
            wr_cnt <= wr_cnt + 1;
            if (bus.rf_write_addr != '0) rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [AW-1:0] p_addr [4];
    logic [DW-1:0] p_data [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        p_addr[0] = 5'd3; p_data[0] = 32'h22222222;
        p_addr[1] = 5'd5; p_data[1] = 32'h44444444;
        p_addr[2] = 5'd3; p_data[2] = 32'hDEADBEEF;
        p_addr[3] = 5'd7; p_data[3] = 32'h66666666;

        reset_n           = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_addr       = '0;
        bus.in_data       = '0;
        bus.rf_grant      = 1'b0;
        bus.lookup_addr_s = '0;
        bus.lookup_addr_t = '0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // Reset state and idle lookups
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_rf_we", 64'(bus.rf_write_enabled), 64'd0);
        check("rst_fwd_t", 64'(bus.fwd_data_t), 64'd0);
        for (int a = 0; a < 32; a++) begin
            bus.lookup_addr_s = AW'(a);
            #1;
            check($sformatf("rst_hit_s_%0d", a), 64'(bus.hit_s), 64'd0);
        end

        // Fill with grant low
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = p_addr[k];
            bus.in_data  = p_data[k];
            #1;
            check($sformatf("fill_ready_%0d", k), 64'(bus.in_ready), 64'd1);
            tick();
        end
        bus.in_valid      = 1'b0;
        bus.lookup_addr_s = 5'd3;
        bus.lookup_addr_t = 5'd9;
        #1;
        check("fill_full", 64'(bus.full), 64'd1);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        check("fill_count", 64'(bus.count), 64'd4);
        check("fill_hit_s3", 64'(bus.hit_s), 64'd1);
        check("fill_fwd_s3", 64'(bus.fwd_data_s), 64'hDEADBEEF);
        check("fill_hit_t9", 64'(bus.hit_t), 64'd0);
        check("fill_fwd_t9", 64'(bus.fwd_data_t), 64'd0);
        bus.lookup_addr_t = 5'd5;
        #1;
        check("fill_fwd_t5", 64'(bus.fwd_data_t), 64'h44444444);

        // Request held against a full buffer is not taken
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd9;
        bus.in_data  = 32'h99999999;
        tick();
        bus.in_valid      = 1'b0;
        bus.lookup_addr_t = 5'd9;
        #1;
        check("full_hold_count", 64'(bus.count), 64'd4);
        check("full_hold_hit_t9", 64'(bus.hit_t), 64'd0);

        // Drain in order, head still hits while popping
        bus.rf_grant      = 1'b1;
        bus.lookup_addr_t = 5'd5;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("drain_we_%0d", k), 64'(bus.rf_write_enabled), 64'd1);
            check($sformatf("drain_addr_%0d", k), 64'(bus.rf_write_addr), 64'(p_addr[k]));
            check($sformatf("drain_data_%0d", k), 64'(bus.rf_write_data), 64'(p_data[k]));
            if (k == 1) check("drain_head_hit_t5", 64'(bus.hit_t), 64'd1);
            tick();
        end
        #1;
        check("drain_empty", 64'(bus.empty), 64'd1);
        check("drain_we_idle", 64'(bus.rf_write_enabled), 64'd0);
        check("drain_addr_idle", 64'(bus.rf_write_addr), 64'd0);
        check("drain_data_idle", 64'(bus.rf_write_data), 64'd0);
        check("drain_hit_s3", 64'(bus.hit_s), 64'd0);
        check("rf3", 64'(rf_mem[3]), 64'hDEADBEEF);
        check("rf5", 64'(rf_mem[5]), 64'h44444444);
        check("rf7", 64'(rf_mem[7]), 64'h66666666);
        check("drain_wr_cnt", 64'(wr_cnt), 64'd4);

        // Write to $zero is accepted and dropped
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_data  = 32'h12345678;
        #1;
        check("zero_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("zero_count", 64'(bus.count), 64'd0);
        check("zero_we", 64'(bus.rf_write_enabled), 64'd0);
        tick();
        check("zero_wr_cnt", 64'(wr_cnt), 64'd4);
        check("zero_rf0", 64'(rf_mem[0]), 64'd0);

        // Streaming push+pop across pointer wrap
        bus.in_valid = 1'b1;
        for (int a = 1; a <= 8; a++) begin
            bus.in_addr       = AW'(a);
            bus.in_data       = 32'h10000000 + 32'(a);
            bus.lookup_addr_s = AW'(a);
            #1;
            if (a == 1) begin
                check("stream_count_0", 64'(bus.count), 64'd0);
                check("stream_we_0", 64'(bus.rf_write_enabled), 64'd0);
            end else begin
                check($sformatf("stream_count_%0d", a), 64'(bus.count), 64'd1);
                check($sformatf("stream_addr_%0d", a), 64'(bus.rf_write_addr), 64'(a - 1));
                check($sformatf("stream_data_%0d", a), 64'(bus.rf_write_data), 64'h10000000 + 64'(a - 1));
            end
            check($sformatf("stream_nohit_%0d", a), 64'(bus.hit_s), 64'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        check("stream_tail_count", 64'(bus.count), 64'd1);
        check("stream_tail_addr", 64'(bus.rf_write_addr), 64'd8);
        tick();
        check("stream_end_count", 64'(bus.count), 64'd0);
        check("stream_wr_cnt", 64'(wr_cnt), 64'd12);
        check("stream_rf8", 64'(rf_mem[8]), 64'h10000008);
        check("stream_rf1", 64'(rf_mem[1]), 64'h10000001);

        // Reset discards pending entries
        bus.rf_grant = 1'b0;
        bus.in_valid = 1'b1;
        for (int a = 10; a < 13; a++) begin
            bus.in_addr = AW'(a);
            bus.in_data = 32'hA0000000 + 32'(a);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        check("prerst_count", 64'(bus.count), 64'd3);
        reset_n = 1'b0;
        tick();
        reset_n           = 1'b1;
        bus.rf_grant      = 1'b1;
        bus.lookup_addr_s = 5'd10;
        #1;
        check("midrst_count", 64'(bus.count), 64'd0);
        check("midrst_empty", 64'(bus.empty), 64'd1);
        check("midrst_we", 64'(bus.rf_write_enabled), 64'd0);
        check("midrst_hit_s", 64'(bus.hit_s), 64'd0);
        tick();
        tick();
        check("midrst_wr_cnt", 64'(wr_cnt), 64'd12);
        check("midrst_rf10", 64'(rf_mem[10]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
